// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: entry capture with valid/ready handshake, branch resolution,
// overflow trap. Define MISALIGN_CHECK_EN to also trap misaligned loads/stores.
module ex_mem_stage #(
    parameter int          DATA_W = 32,
    parameter int          REG_AW = 5,
    parameter logic [4:0]  EXC_OV = 5'd12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic              in_zero,
    input  logic              in_great,
    input  logic              in_overflow,
    input  logic              in_trap_en,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_wreg,
    input  logic              in_reg_we,
    input  logic              in_mem_re,
    input  logic              in_mem_we,
    input  logic [1:0]        in_mem_size,
    input  logic [2:0]        in_br_type,
    input  logic [DATA_W-1:0] in_br_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_wreg,
    output logic              out_reg_we,
    output logic              out_mem_re,
    output logic              out_mem_we,
    output logic [1:0]        out_mem_size,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              exc_valid,
    output logic [DATA_W-1:0] exc_epc,
    output logic [4:0]        exc_code
);

    typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_alu_out;
    logic [DATA_W-1:0] r_store_data;
    logic [REG_AW-1:0] r_wreg;
    logic              r_reg_we;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [1:0]        r_mem_size;
    logic              r_br_taken;
    logic [DATA_W-1:0] r_br_target;
    logic              r_exc_valid;
    logic [DATA_W-1:0] r_exc_epc;
    logic [4:0]        r_exc_code;

    logic       w_ready;
    logic       w_accept;
    logic       w_ovf_trap;
    logic       w_misalign;
    logic       w_exc;
    logic [4:0] w_exc_code;

    // Types 5-7 are reserved and resolve as not-taken.
    function automatic logic br_cond(input logic [2:0] typ, input logic zero, input logic great);
        case (typ)
            3'd1:    br_cond = zero;
            3'd2:    br_cond = !zero;
            3'd3:    br_cond = great;
            3'd4:    br_cond = !great;
            default: br_cond = 1'b0;
        endcase
    endfunction

    assign w_accept   = in_valid && w_ready && !flush;
    assign w_ovf_trap = in_overflow && in_trap_en;

`ifdef MISALIGN_CHECK_EN
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    assign w_misalign = (in_mem_re || in_mem_we) &&
                        (((in_mem_size == 2'd1) && in_alu_out[0]) ||
                         ((in_mem_size == 2'd2) && (in_alu_out[1:0] != 2'b00)));
    assign w_exc_code = w_ovf_trap ? EXC_OV : (in_mem_re ? EXC_ADEL : EXC_ADES);
`else
    assign w_misalign = 1'b0;
    assign w_exc_code = EXC_OV;
`endif

    assign w_exc = w_accept && (w_ovf_trap || w_misalign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush)      w_state_nxt = S_RUN;
        else if (w_exc) w_state_nxt = S_TRAP;
    end

    always_comb begin
        w_ready = (r_state == S_RUN) && (!r_valid || out_ready);
    end

    // Entry register; flush wins over accept and stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_alu_out    <= '0;
            r_store_data <= '0;
            r_wreg       <= '0;
            r_reg_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_size   <= 2'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_pc         <= in_pc;
            r_alu_out    <= in_alu_out;
            r_store_data <= in_store_data;
            r_wreg       <= in_wreg;
            r_reg_we     <= in_reg_we && !w_exc;
            r_mem_re     <= in_mem_re && !w_exc;
            r_mem_we     <= in_mem_we && !w_exc;
            r_mem_size   <= in_mem_size;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_exc_valid <= 1'b0;
            r_exc_epc   <= '0;
            r_exc_code  <= 5'd0;
        end else begin
            r_br_taken  <= w_accept && !w_exc && br_cond(in_br_type, in_zero, in_great);
            r_exc_valid <= w_exc;
            if (w_accept) r_br_target <= in_br_target;
            if (w_exc) begin
                r_exc_epc  <= in_pc;
                r_exc_code <= w_exc_code;
            end
        end
    end

    assign in_ready       = w_ready;
    assign out_valid      = r_valid;
    assign out_pc         = r_pc;
    assign out_alu_out    = r_alu_out;
    assign out_store_data = r_store_data;
    assign out_wreg       = r_wreg;
    assign out_reg_we     = r_reg_we;
    assign out_mem_re     = r_mem_re;
    assign out_mem_we     = r_mem_we;
    assign out_mem_size   = r_mem_size;
    assign br_taken       = r_br_taken;
    assign br_target      = r_br_target;
    assign exc_valid      = r_exc_valid;
    assign exc_epc        = r_exc_epc;
    assign exc_code       = r_exc_code;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the stage.
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_pc, in_alu_out, in_store_data, in_br_target;
    logic              in_zero, in_great, in_overflow, in_trap_en;
    logic [REG_AW-1:0] in_wreg;
    logic              in_reg_we, in_mem_re, in_mem_we;
    logic [1:0]        in_mem_size;
    logic [2:0]        in_br_type;
    logic              flush;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_pc, out_alu_out, out_store_data;
    logic [REG_AW-1:0] out_wreg;
    logic              out_reg_we, out_mem_re, out_mem_we;
    logic [1:0]        out_mem_size;
    logic              br_taken;
    logic [DATA_W-1:0] br_target;
    logic              exc_valid;
    logic [DATA_W-1:0] exc_epc;
    logic [4:0]        exc_code;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .EXC_OV(5'd12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu_out(in_alu_out),
        .in_zero(in_zero), .in_great(in_great),
        .in_overflow(in_overflow), .in_trap_en(in_trap_en),
        .in_store_data(in_store_data), .in_wreg(in_wreg),
        .in_reg_we(in_reg_we), .in_mem_re(in_mem_re), .in_mem_we(in_mem_we),
        .in_mem_size(in_mem_size), .in_br_type(in_br_type), .in_br_target(in_br_target),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_out(out_alu_out), .out_store_data(out_store_data),
        .out_wreg(out_wreg), .out_reg_we(out_reg_we), .out_mem_re(out_mem_re),
        .out_mem_we(out_mem_we), .out_mem_size(out_mem_size),
        .br_taken(br_taken), .br_target(br_target),
        .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_code(exc_code)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
        logic [REG_AW-1:0] wreg;
        logic              reg_we;
        logic              mem_re;
        logic              mem_we;
        logic [1:0]        size;
    } entry_t;

    entry_t            m_ent;
    logic              m_valid, m_trapped, m_br, m_exc;
    logic [DATA_W-1:0] m_br_tgt, m_epc;
    logic [4:0]        m_code;

    function automatic logic taken_rule(input logic [2:0] t, input logic z, input logic g);
        return (t == 3'd1 && z) || (t == 3'd2 && !z) || (t == 3'd3 && g) || (t == 3'd4 && !g);
    endfunction

    function automatic logic misaligned_rule(input logic re, input logic we, input logic [1:0] sz,
                                             input logic [DATA_W-1:0] a);
`ifdef MISALIGN_CHECK_EN
        if (!(re || we)) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ent = '0; m_valid = 0; m_trapped = 0; m_br = 0; m_exc = 0;
            m_br_tgt = '0; m_epc = '0; m_code = '0;
        end else begin
            logic can_take, take, ovf, mis, fault;
            can_take = !m_trapped && (!m_valid || out_ready);
            take     = in_valid && can_take && !flush;
            ovf      = in_overflow && in_trap_en;
            mis      = misaligned_rule(in_mem_re, in_mem_we, in_mem_size, in_alu_out);
            fault    = take && (ovf || mis);
            m_br     = take && !fault && taken_rule(in_br_type, in_zero, in_great);
            m_exc    = fault;
            if (take) m_br_tgt = in_br_target;
            if (fault) begin
                m_epc  = in_pc;
                m_code = ovf ? 5'd12 : (in_mem_re ? 5'd4 : 5'd5);
            end
            if (flush) begin
                m_valid = 0;
                m_trapped = 0;
            end else begin
                if (take) begin
                    m_ent = '{pc: in_pc, alu: in_alu_out, sdata: in_store_data, wreg: in_wreg,
                              reg_we: in_reg_we && !fault, mem_re: in_mem_re && !fault,
                              mem_we: in_mem_we && !fault, size: in_mem_size};
                    m_valid = 1;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                if (fault) m_trapped = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [178:0] act, exp;
        logic         exp_rdy;
        exp_rdy = !m_trapped && (!m_valid || out_ready);
        act = {out_valid, in_ready, out_pc, out_alu_out, out_store_data, out_wreg, out_reg_we,
               out_mem_re, out_mem_we, out_mem_size, br_taken, br_target, exc_valid, exc_epc,
               exc_code};
        exp = {m_valid, exp_rdy, m_ent.pc, m_ent.alu, m_ent.sdata, m_ent.wreg, m_ent.reg_we,
               m_ent.mem_re, m_ent.mem_we, m_ent.size, m_br, m_br_tgt, m_exc, m_epc, m_code};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h", $time, act, exp);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = '0; in_alu_out = '0; in_zero = 0; in_great = 0;
        in_overflow = 0; in_trap_en = 0; in_store_data = '0; in_wreg = '0;
        in_reg_we = 0; in_mem_re = 0; in_mem_we = 0; in_mem_size = 2'd0;
        in_br_type = 3'd0; in_br_target = '0; flush = 0; out_ready = 1;
    endtask

    task automatic rand_inputs();
        in_valid      = ($urandom_range(0, 3) != 0);
        in_pc         = $urandom & 32'hFFFF_FFFC;
        in_alu_out    = $urandom;
        in_zero       = $urandom_range(0, 1);
        in_great      = $urandom_range(0, 1);
        in_overflow   = ($urandom_range(0, 3) == 0);
        in_trap_en    = ($urandom_range(0, 3) == 0);
        in_store_data = $urandom;
        in_wreg       = 5'($urandom);
        in_reg_we     = $urandom_range(0, 1);
        in_mem_re     = ($urandom_range(0, 3) == 0);
        in_mem_we     = !in_mem_re && ($urandom_range(0, 3) == 0);
        in_mem_size   = 2'($urandom_range(0, 3));
        in_br_type    = 3'($urandom_range(0, 7));
        in_br_target  = $urandom;
        flush         = ($urandom_range(0, 11) == 0);
        out_ready     = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_exc_code", 64'(exc_code), 64'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // basic pass-through
        @(posedge clk); #2;
        in_valid = 1; in_alu_out = 32'h10; in_wreg = 5'd3; in_reg_we = 1;
        tick();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_alu", 64'(out_alu_out), 64'h10);
        chk("basic_wreg", 64'(out_wreg), 64'd3);
        in_valid = 0;
        tick();
        chk("basic_drain", 64'(out_valid), 64'd0);

        // stall: A held, B waits
        out_ready = 0; in_valid = 1; in_alu_out = 32'h1;
        tick();
        chk("stall_A", 64'(out_alu_out), 64'h1);
        chk("stall_ready", 64'(in_ready), 64'd0);
        in_alu_out = 32'h2;
        tick();
        chk("stall_hold", 64'(out_alu_out), 64'h1);
        out_ready = 1;
        tick();
        chk("stall_B", 64'(out_alu_out), 64'h2);
        chk("stall_B_valid", 64'(out_valid), 64'd1);
        in_valid = 0;
        tick();
        chk("stall_empty", 64'(out_valid), 64'd0);

        // branch taken / not taken
        in_valid = 1; in_br_type = 3'd1; in_zero = 1; in_br_target = 32'h0040_0100;
        tick();
        chk("br_eq_taken", 64'(br_taken), 64'd1);
        chk("br_target", 64'(br_target), 64'h0040_0100);
        in_br_type = 3'd2;
        tick();
        chk("br_ne_not", 64'(br_taken), 64'd0);
        idle_inputs();
        tick();

        // overflow trap
        in_valid = 1; in_pc = 32'h0040_0020; in_overflow = 1; in_trap_en = 1; in_reg_we = 1;
        tick();
        chk("trap_exc_valid", 64'(exc_valid), 64'd1);
        chk("trap_epc", 64'(exc_epc), 64'h0040_0020);
        chk("trap_code", 64'(exc_code), 64'd12);
        chk("trap_reg_we", 64'(out_reg_we), 64'd0);
        chk("trap_ready", 64'(in_ready), 64'd0);
        in_overflow = 0; in_pc = 32'h0040_0024;
        tick();
        chk("trap_pulse_end", 64'(exc_valid), 64'd0);
        chk("trap_still_blocked", 64'(in_ready), 64'd0);
        chk("trap_epc_hold", 64'(exc_epc), 64'h0040_0020);
        in_valid = 0; flush = 1;
        tick();
        flush = 0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);

        // flush with a held entry and an incoming one
        out_ready = 0; in_valid = 1; in_alu_out = 32'h55; in_br_type = 3'd1; in_zero = 1;
        tick();
        in_alu_out = 32'h66; flush = 1;
        tick();
        chk("flushc_valid", 64'(out_valid), 64'd0);
        chk("flushc_br", 64'(br_taken), 64'd0);
        idle_inputs();
        tick();
        chk("flushc_no_ghost", 64'(out_valid), 64'd0);

        // alignment
        in_valid = 1; in_mem_re = 1; in_mem_size = 2'd2; in_alu_out = 32'h0000_1002;
        tick();
`ifdef MISALIGN_CHECK_EN
        chk("mis_ld_exc", 64'(exc_valid), 64'd1);
        chk("mis_ld_code", 64'(exc_code), 64'd4);
        chk("mis_ld_re", 64'(out_mem_re), 64'd0);
`else
        chk("mis_ld_exc", 64'(exc_valid), 64'd0);
        chk("mis_ld_re", 64'(out_mem_re), 64'd1);
`endif
        idle_inputs(); flush = 1;
        tick();
        flush = 0;
        in_valid = 1; in_mem_we = 1; in_mem_size = 2'd1; in_alu_out = 32'h3;
        tick();
`ifdef MISALIGN_CHECK_EN
        chk("mis_st_exc", 64'(exc_valid), 64'd1);
        chk("mis_st_code", 64'(exc_code), 64'd5);
`else
        chk("mis_st_exc", 64'(exc_valid), 64'd0);
        chk("mis_st_we", 64'(out_mem_we), 64'd1);
`endif
        idle_inputs(); flush = 1;
        tick();
        flush = 0;

        // randomized traffic, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rand_inputs();
            if (i == 1500) begin
                rst_n = 0;
                @(posedge clk); #3;
                rst_n = 1;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute-stage ALU and the memory stage.
- Captures the ALU result and flags, plus the control fields that travel with the instruction.
- Resolves conditional branches from the ALU zero/great flags.
- Converts ALU overflow on trapping instructions into an exception request.
- Uses a valid/ready handshake; supports flush and stall from the hazard/exception controller.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, PC)
- REG_AW, 5, register-file address width
- EXC_OV, 5'd12, exception code for arithmetic overflow

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  DATA_W  PC of EX instruction
- in_alu_out  in  DATA_W  ALU result
- in_zero  in  1  ALU zero flag
- in_great  in  1  ALU great flag
- in_overflow  in  1  ALU overflow flag
- in_trap_en  in  1  instruction traps on overflow
- in_store_data  in  DATA_W  rt value for stores
- in_wreg  in  REG_AW  destination register
- in_reg_we  in  1  register write enable
- in_mem_re  in  1  load
- in_mem_we  in  1  store
- in_mem_size  in  2  0 byte, 1 half, 2 word
- in_br_type  in  3  0 none, 1 eq(zero), 2 ne(!zero), 3 gt(great), 4 le(!great); 5-7 treated as none
- in_br_target  in  DATA_W  branch target
- flush  in  1  kill held and incoming instruction
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry
- out_pc, out_alu_out, out_store_data  out  DATA_W  registered copies
- out_wreg  out  REG_AW  registered copy
- out_reg_we, out_mem_re, out_mem_we  out  1  registered copies, forced 0 on exception
- out_mem_size  out  2  registered copy
- br_taken  out  1  one-cycle pulse, branch resolved taken
- br_target  out  DATA_W  target valid with br_taken
- exc_valid  out  1  one-cycle exception pulse
- exc_epc  out  DATA_W  PC of faulting instruction
- exc_code  out  5  exception code

Behaviour:
- Reset (rst_n low, async):
  - All outputs and registers go to 0; state = RUN.
  - in_ready = 1 once reset is released.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Accept = in_valid && in_ready && !flush.
  - Latency from accept to out_valid is 1 cycle.
- Entry register:
  - On accept, all out_* fields load from in_*.
  - out_valid is set when an entry is accepted.
  - out_valid clears when out_ready is high and there is no accept in the same cycle.
  - With out_valid && !out_ready, every field holds (stall).
  - Back-to-back: out_ready and accept in the same cycle replace the entry with no bubble.
- Branch:
  - On accept, br_taken <= condition of in_br_type evaluated on in_zero/in_great.
  - br_target <= in_br_target.
  - br_taken is high for exactly one cycle per accepted instruction; otherwise 0.
  - A trapped instruction never asserts br_taken.
- Overflow trap:
  - Trigger: accept && in_overflow && in_trap_en.
  - The entry is captured with out_reg_we/out_mem_re/out_mem_we = 0.
  - exc_valid pulses for 1 cycle with exc_epc = in_pc and exc_code = EXC_OV.
  - State moves to TRAP.
  - in_overflow without in_trap_en is ignored.
- States:
  - RUN -> TRAP on a trap.
  - TRAP: in_ready = 0; the held entry still drains normally through out_ready.
  - TRAP -> RUN only on flush.
- Flush:
  - Synchronous.
  - Clears out_valid, br_taken and exc_valid next cycle; returns state to RUN.
  - The same-cycle incoming instruction is dropped.
  - Flush has priority over accept, trap and stall.
- Reset mid-operation discards the entry and any pending TRAP immediately.
- exc_epc and exc_code hold their last values after the pulse.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Misalignment check on accept when in_mem_re or in_mem_we is set.
  - Misaligned: size 1 with in_alu_out[0] set, or size 2 with in_alu_out[1:0] nonzero.
  - A misaligned access raises an exception like the overflow trap, with exc_code 4 for loads and 5 for stores.
  - Overflow takes priority if both occur.
- Undefined:
  - No alignment checking; misaligned addresses pass through unmodified.

Test Plan:
- Reset, then in_valid with alu_out=0x00000010, wreg=3, reg_we=1, out_ready=1 -> next cycle out_valid=1, out_alu_out=0x10, out_wreg=3; following cycle out_valid=0 with in_valid=0.
- Stall: out_ready=0, two in_valid instructions A (alu_out 0x1) and B (0x2) -> A held, in_ready=0, B not accepted; raise out_ready -> B appears the cycle after, with no loss or duplication.
- Branch: br_type=1, in_zero=1, target 0x00400100 -> br_taken pulses 1 cycle with br_target=0x00400100; br_type=2, in_zero=1 -> br_taken stays 0.
- Trap: pc=0x00400020, in_overflow=1, in_trap_en=1, reg_we=1 -> exc_valid 1-cycle pulse, exc_epc=0x00400020, exc_code=12, out_reg_we=0, in_ready=0 until flush; flush -> out_valid=0, in_ready=1.
- Flush concurrent with in_valid and a held entry -> next cycle out_valid=0, the incoming instruction never appears, br_taken=0.
- MISALIGN_CHECK_EN: load, size 2, alu_out=0x00001002 -> exc_code=4, out_mem_re=0; store, size 1, alu_out=0x3 -> exc_code=5. Without the macro, both pass with exc_valid=0.
